// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with the HI/LO registers.
//
// A Start pulse in an idle cycle latches the operation, computes the 64-bit
// result into pending registers and loads a 4-bit down-counter. Busy is high
// while the counter is non-zero. The edge that takes the counter to zero
// commits the pending result to HI/LO. mthi/mtlo writes go through HiLoWe
// and only take effect while the unit is idle.
//
// Optional feature macro: MDU_MADD_EN enables madd (110) and maddu (111),
// which accumulate the product onto the {HI,LO} value sampled at Start.
// Without the macro, Start with MDOp 110/111 is ignored.
//
// Ports:
//   clk     in   1   pipeline clock, all state updates on posedge
//   reset   in   1   asynchronous active-high reset, clears all state
//   A       in  32   operand rs
//   B       in  32   operand rt
//   MDOp    in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi,
//                    101 mtlo, 110 madd, 111 maddu
//   Start   in   1   one-cycle launch pulse for MDOp 000-011 / 110-111
//   HiLoWe  in   1   write strobe for mthi/mtlo (MDOp 100/101)
//   Busy    out  1   operation in flight
//   HI      out 32   HI register
//   LO      out 32   LO register

module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        Start,
    input  logic        HiLoWe,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

    logic [3:0]  counter_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;
    logic        pend_we_q;

    logic        idle;
    logic        op_ok;
    logic [3:0]  op_cycles;
    logic [63:0] op_result;
    logic        op_we;
    logic        start_go;
    logic        write_go;

    // Multipliers: the low 64 bits of the sign-extended product equal the
    // signed 32x32 product.
    logic [63:0] prod_u;
    logic [63:0] prod_s;

    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

    // Divider: signed division runs on magnitudes and the signs are fixed up
    // afterwards, so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    logic        div_signed;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q_raw;
    logic [31:0] r_raw;
    logic [31:0] quot;
    logic [31:0] rem;

    assign div_signed = (MDOp == 3'b010);
    assign dvd = (div_signed && A[31]) ? (~A + 32'd1) : A;
    assign dvs = (div_signed && B[31]) ? (~B + 32'd1) : B;
    assign q_raw = (dvs == 32'd0) ? 32'd0 : (dvd / dvs);
    assign r_raw = (dvs == 32'd0) ? 32'd0 : (dvd % dvs);
    assign quot = (div_signed && (A[31] ^ B[31])) ? (~q_raw + 32'd1) : q_raw;
    assign rem  = (div_signed && A[31]) ? (~r_raw + 32'd1) : r_raw;

    assign idle = (counter_q == 4'd0);

    always_comb begin
        op_ok     = 1'b0;
        op_cycles = 4'd0;
        op_result = 64'd0;
        op_we     = 1'b0;
        case (MDOp)
            3'b000: begin
                op_ok     = 1'b1;
                op_cycles = MultLoad;
                op_result = prod_s;
                op_we     = 1'b1;
            end
            3'b001: begin
                op_ok     = 1'b1;
                op_cycles = MultLoad;
                op_result = prod_u;
                op_we     = 1'b1;
            end
            3'b010, 3'b011: begin
                op_ok     = 1'b1;
                op_cycles = DivLoad;
                op_result = {rem, quot};
                // Divide by zero still occupies the unit but leaves HI/LO alone.
                op_we     = (B != 32'd0);
            end
`ifdef MDU_MADD_EN
            3'b110: begin
                op_ok     = 1'b1;
                op_cycles = MultLoad;
                op_result = {hi_q, lo_q} + prod_s;
                op_we     = 1'b1;
            end
            3'b111: begin
                op_ok     = 1'b1;
                op_cycles = MultLoad;
                op_result = {hi_q, lo_q} + prod_u;
                op_we     = 1'b1;
            end
`else
            3'b110, 3'b111: begin
                op_ok = 1'b0;
            end
`endif
            default: begin
                op_ok = 1'b0;
            end
        endcase
    end

    assign start_go = Start && idle && op_ok;
    // An accepted Start in the same cycle takes priority over a register write.
    assign write_go = HiLoWe && idle && !start_go && (MDOp[2:1] == 2'b10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else if (idle) begin
            if (start_go) begin
                counter_q <= op_cycles;
                pend_hi_q <= op_result[63:32];
                pend_lo_q <= op_result[31:0];
                pend_we_q <= op_we;
            end else if (write_go) begin
                if (MDOp[0]) begin
                    lo_q <= A;
                end else begin
                    hi_q <= A;
                end
            end
        end else begin
            counter_q <= counter_q - 4'd1;
            if ((counter_q == 4'd1) && pend_we_q) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end
        end
    end

    assign Busy = !idle;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, with the HI/LO architectural registers.
- Accepts a one-cycle Start pulse from the EX-stage decode and latches operands.
- Asserts Busy for a fixed latency, then commits the result to HI/LO.
- Start and Busy are the stall sources consumed by the hazard unit in ID.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10, cycles Busy stays high for div/divu; legal range 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- A  in  32  operand rs (forwarded value).
- B  in  32  operand rt (forwarded value).
- MDOp  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu.
- Start  in  1  one-cycle pulse launching an MDOp 000-011/110-111 operation.
- HiLoWe  in  1  write strobe for mthi/mtlo (MDOp 100/101).
- Busy  out  1  operation in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset (async): HI=0, LO=0, Busy=0, counter=0, pending result=0. Reset asserted mid-operation aborts it; no commit occurs.
- Idle state (counter=0):
  - Start=1 at edge k: latch A, B and MDOp, compute the 64-bit result into pending regs, and load counter with MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from after edge k through edge k+N-1.
  - At edge k+N: counter reaches 0, HI/LO take the pending values, Busy=0.
  - HI/LO are readable with new values in the cycle after edge k+N.
- Busy is registered: Busy = (counter != 0). Start itself does not raise Busy in its own cycle; the hazard unit ORs Start in separately.
- Mult/multu: {HI,LO} = A*B, 64-bit, signed or unsigned respectively.
- Div (signed): LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divu: unsigned quotient and remainder.
- Divide by zero (B=0): runs the full DIV_CYCLES with Busy; HI/LO are left unchanged at commit.
- mthi/mtlo: HiLoWe=1 with counter=0 writes A into HI (100) or LO (101) at the edge; visible next cycle.
- Start while Busy: ignored; the operation in flight continues unaffected.
- HiLoWe while Busy: ignored; the HI/LO commit is unaffected.
- Start and HiLoWe together in an idle cycle: Start wins and HiLoWe is ignored.
- Start with MDOp 100/101: ignored.
- HiLoWe with MDOp other than 100/101: ignored.
- HI/LO hold their value during Busy. Reads (mfhi/mflo) are stalled by the hazard unit, not by this block.
- Counter width is 4 bits.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: MDOp 110 (madd) and 111 (maddu) with Start run for MULT_CYCLES.
  - At commit, {HI,LO} = {HI,LO} + A*B (signed or unsigned product), using the HI/LO values sampled at Start; 64-bit wrap-around.
- Undefined: Start with MDOp 110/111 is ignored (Busy stays 0, HI/LO unchanged).

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3 with Start at edge 1 -> Busy=1 for edges 1-4 and 0 after edge 5; HI=0xFFFFFFFF, LO=0xFFFFFFFA after edge 5.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: mthi 0x11, then mtlo 0x22, then divu A=5, B=0 -> Busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
- Start a div, pulse Start(mult) and HiLoWe(mthi) at cycle 3, then assert reset at cycle 6 -> the second Start and the write have no effect; reset clears Busy, HI and LO immediately, with no later commit.
- With MDU_MADD_EN: mtlo 0xFFFFFFFF, then mthi 0, then maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus -> Busy stays 0 and HI/LO are unchanged.
